// File: rtl/sr_flag_pkg.sv
// Shared types and helpers for the SR flag arbiter: command encoding,
// FSM state encoding, error-counter ceiling and the per-flag update rule.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_TGL  = 2'b11
  } flag_cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } arb_state_e;

  localparam logic [7:0] ERRCNT_MAX = 8'd255;

  // New value of one flag bit after a JK-style command.
  function automatic logic apply_cmd(input logic cur, input flag_cmd_e cmd);
    logic nxt;
    case (cmd)
      CMD_HOLD: nxt = cur;
      CMD_RST:  nxt = 1'b0;
      CMD_SET:  nxt = 1'b1;
      CMD_TGL:  nxt = ~cur;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting at
// ptr_i and wrapping modulo NREQ; the first asserted request wins.
module sr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [GW-1:0]   grant_id_o,
  output logic            any_req_o
);

  // Rotating priority search from the pointer upward.
  always_comb begin
    int   cand;
    logic found;
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    cand       = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[cand[GW-1:0]]) begin
        found                    = 1'b1;
        grant_o[cand[GW-1:0]]    = 1'b1;
        grant_id_o               = cand[GW-1:0];
      end else begin
        found = found;
      end
    end
    any_req_o = found;
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin sequencer for a shared bank of SR status flags.
// IDLE picks a requester and latches its command; APPLY strobes ready to
// that requester and commits the command to the flag bank at the end of
// the cycle. One command per two cycles.
// Optional build macro SR_FLAG_ERRCNT_EN adds a saturating 8-bit count of
// out-of-range index commands on port err_cnt.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [2*NREQ-1:0]             req_cmd,
  input  logic [IDXW*NREQ-1:0]          req_idx,
  output logic [NREQ-1:0]               req_ready,
  output logic [NFLAGS-1:0]             flags,
  output logic                          busy,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                          err_idx
`ifdef SR_FLAG_ERRCNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  import sr_flag_pkg::*;

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gid_q;
  flag_cmd_e         cmd_q;
  logic [IDXW-1:0]   idx_q;
  logic [NFLAGS-1:0] flags_q, flags_d;

  logic [NREQ-1:0]   arb_grant_s;
  logic [GW-1:0]     arb_gid_s;
  logic              any_req_s;
  flag_cmd_e         sel_cmd_s;
  logic [IDXW-1:0]   sel_idx_s;
  logic              in_range_s;

  sr_rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req_i      (req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant_s),
    .grant_id_o (arb_gid_s),
    .any_req_o  (any_req_s)
  );

  // Route the winning requester's command and index to the latch.
  always_comb begin
    sel_cmd_s = CMD_HOLD;
    sel_idx_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant_s[i]) begin
        sel_cmd_s = flag_cmd_e'(req_cmd[2*i +: 2]);
        sel_idx_s = req_idx[IDXW*i +: IDXW];
      end else begin
        sel_cmd_s = sel_cmd_s;
      end
    end
  end

  assign in_range_s = (int'(idx_q) < NFLAGS);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE waits for any request, APPLY always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) state_d = ST_APPLY;
        else           state_d = ST_IDLE;
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; reset masks the strobes so an aborted command is never acknowledged.
  always_comb begin
    req_ready = '0;
    busy      = (state_q == ST_APPLY);
    grant_id  = gid_q;
    err_idx   = (state_q == ST_APPLY) && !in_range_s && !reset;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_q == ST_APPLY) && !reset && (int'(gid_q) == i)) req_ready[i] = 1'b1;
      else                                                        req_ready[i] = 1'b0;
    end
  end

  // Capture the winner's id, command and index when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      gid_q <= '0;
      cmd_q <= CMD_HOLD;
      idx_q <= '0;
    end else if ((state_q == ST_IDLE) && any_req_s) begin
      gid_q <= arb_gid_s;
      cmd_q <= sel_cmd_s;
      idx_q <= sel_idx_s;
    end else begin
      gid_q <= gid_q;
      cmd_q <= cmd_q;
      idx_q <= idx_q;
    end
  end

  // Next flag bank and RR pointer: only APPLY changes them.
  always_comb begin
    flags_d = flags_q;
    ptr_d   = ptr_q;
    if (state_q == ST_APPLY) begin
      ptr_d = (int'(gid_q) == NREQ-1) ? '0 : gid_q + GW'(1);
      for (int f = 0; f < NFLAGS; f++) begin
        if (int'(idx_q) == f) flags_d[f] = apply_cmd(flags_q[f], cmd_q);
        else                  flags_d[f] = flags_q[f];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag bank and RR pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      ptr_q   <= '0;
    end else begin
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
    end
  end

  assign flags = flags_q;

`ifdef SR_FLAG_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of out-of-range commands served since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (err_idx && (err_cnt_q != ERRCNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a transaction-level model predicts
// the service order and flag contents; a monitor checks each ready strobe.
module tb_sr_flag_arbiter;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;
  localparam int IDXW   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req_valid;
  logic [2*NREQ-1:0]        req_cmd;
  logic [IDXW*NREQ-1:0]     req_idx;
  logic [NREQ-1:0]          req_ready;
  logic [NFLAGS-1:0]        flags;
  logic                     busy;
  logic [1:0]               grant_id;
  logic                     err_idx;
`ifdef SR_FLAG_ERRCNT_EN
  logic [7:0]               err_cnt;
`endif

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .flags     (flags),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_idx   (err_idx)
`ifdef SR_FLAG_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] cmd; logic [3:0] idx; } cmd_t;
  typedef struct { int id; bit err; logic [7:0] flags; int cnt; } exp_t;

  cmd_t pend[NREQ][$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // model state
  int         m_ptr;
  logic [7:0] m_flags;
  int         m_cnt;

  // monitor state
  bit         flag_chk_pend = 0;
  exp_t       cur_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_flags = 8'h00; m_cnt = 0;
  endtask

  // Transaction model: every requester with work left is valid at each
  // arbitration; winner is first one at or after the pointer.
  task automatic model_batch();
    cmd_t mq[NREQ][$];
    int   left;
    for (int i = 0; i < NREQ; i++) mq[i] = pend[i];
    left = 0;
    for (int i = 0; i < NREQ; i++) left += mq[i].size();
    while (left > 0) begin
      int   win;
      cmd_t c;
      exp_t e;
      win = -1;
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && mq[(m_ptr + k) % NREQ].size() > 0) win = (m_ptr + k) % NREQ;
      c = mq[win].pop_front();
      left--;
      e.id  = win;
      e.err = (c.idx >= NFLAGS);
      if (!e.err) begin
        if (c.cmd == 2'd1) m_flags[c.idx] = 1'b0;
        else if (c.cmd == 2'd2) m_flags[c.idx] = 1'b1;
        else if (c.cmd == 2'd3) m_flags[c.idx] = ~m_flags[c.idx];
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
      e.flags = m_flags;
      e.cnt   = m_cnt;
      sb.push_back(e);
      m_ptr = (win + 1) % NREQ;
    end
  endtask

  task automatic load(input int i);
    cmd_t c;
    c = pend[i][0];
    req_valid[i]            = 1'b1;
    req_cmd[2*i +: 2]       = c.cmd;
    req_idx[IDXW*i +: IDXW] = c.idx;
  endtask

  // Drive all pending commands; call at a negedge with the DUT idle.
  task automatic run_batch();
    int cyc;
    int left;
    model_batch();
    for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) load(i);
    cyc = 0;
    left = 0;
    for (int i = 0; i < NREQ; i++) left += pend[i].size();
    while (left > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("first_ready_latency", {31'd0, (req_ready != 4'd0)}, 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          void'(pend[i].pop_front());
          left--;
          if (pend[i].size() > 0) load(i);
          else req_valid[i] = 1'b0;
        end
      end
    end
    if (left > 0) begin
      checks++; errors++;
      $display("FAIL batch_timeout actual=%0d required=0", left);
      for (int i = 0; i < NREQ; i++) pend[i].delete();
      req_valid = '0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_reset();
  endtask

  // Monitor: pops one expectation per ready strobe; checks flags next cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (flag_chk_pend) begin
        flag_chk_pend = 0;
        chk("flags_after", {24'd0, flags}, {24'd0, cur_exp.flags});
        chk("ready_one_cycle", {28'd0, req_ready}, 32'd0);
`ifdef SR_FLAG_ERRCNT_EN
        chk("err_cnt", {24'd0, err_cnt}, cur_exp.cnt);
`endif
      end
      if (req_ready !== 4'd0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready actual=%0h required=0", req_ready);
        end else begin
          cur_exp = sb.pop_front();
          chk("ready_onehot", {28'd0, req_ready}, 32'd1 << cur_exp.id);
          chk("grant_id", {30'd0, grant_id}, cur_exp.id);
          chk("busy", {31'd0, busy}, 32'd1);
          chk("err_idx", {31'd0, err_idx}, {31'd0, cur_exp.err});
          flag_chk_pend = 1;
        end
      end
    end
  end

  initial begin
    cmd_t c;
    reset = 1'b1; req_valid = '0; req_cmd = '0; req_idx = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    repeat (4) begin
      @(negedge clk);
      chk("idle_flags", {24'd0, flags}, 32'h00);
      chk("idle_ready", {28'd0, req_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_gid", {30'd0, grant_id}, 32'd0);
      chk("idle_err", {31'd0, err_idx}, 32'd0);
    end

    // req0 set idx3 -> 0x08
    c.cmd = 2'd2; c.idx = 4'd3; pend[0].push_back(c);
    run_batch();
    chk("set3_flags", {24'd0, flags}, 32'h08);

    // req1 toggle idx3 twice
    c.cmd = 2'd3; c.idx = 4'd3; pend[1].push_back(c); pend[1].push_back(c);
    run_batch();
    chk("tgl_flags", {24'd0, flags}, 32'h08);

    // all four contending from pointer 0; req0 returns for a fifth grant
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      c.cmd = 2'd2; c.idx = 4'(i); pend[i].push_back(c);
    end
    c.cmd = 2'd0; c.idx = 4'd0; pend[0].push_back(c);
    run_batch();
    chk("rr_final_flags", {24'd0, flags}, 32'h0F);

    // out-of-range index from req2
    c.cmd = 2'd1; c.idx = 4'd9; pend[2].push_back(c);
    run_batch();
    chk("oob_flags", {24'd0, flags}, 32'h0F);

    // reset during APPLY of set idx5
    @(negedge clk);
    req_valid[0] = 1'b1; req_cmd[1:0] = 2'd2; req_idx[3:0] = 4'd5;
    @(posedge clk); #1;
    chk("apply_entered", {31'd0, busy}, 32'd1);
    reset = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("rst_apply_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rst_apply_flags", {24'd0, flags}, 32'h00);
    chk("rst_apply_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    sb.delete();
    model_reset();
    // pointer back at 0: req0 must beat req3
    c.cmd = 2'd2; c.idx = 4'd1; pend[3].push_back(c);
    c.cmd = 2'd2; c.idx = 4'd2; pend[0].push_back(c);
    run_batch();

    // random batches
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = $urandom_range(2, 0);
        for (int j = 0; j < n; j++) begin
          c.cmd = 2'($urandom_range(3, 0));
          c.idx = 4'($urandom_range(11, 0));
          pend[i].push_back(c);
        end
      end
      run_batch();
      if (($urandom_range(9, 0)) == 0) do_reset();
    end

    @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
